// File: rtl/axi_sram_pkg.sv
// Shared types and SRAM geometry for the AXI-to-SRAM bridge.
// The chunk breaker, assembler and port arbiter all import this package.
package axi_sram_pkg;

    localparam int SRAM_ADDR_W   = 10;
    localparam int SRAM_DATA_W   = 8;
    localparam int MAX_BEATS_DEF = 8;
    localparam int BEAT_CNT_W    = 4;

    typedef enum logic {
        WR = 1'b0,
        RD = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } arb_state_t;

endpackage

// File: rtl/axi_sram_rr_pick.sv
// Combinational two-way round-robin pick: on a tie the requester that did
// not own the port last time wins.
module axi_sram_rr_pick
    import axi_sram_pkg::*;
(
    input  logic   req_wr,
    input  logic   req_rd,
    input  owner_t last_owner,
    output logic   pick_valid,
    output owner_t winner
);

    always_comb begin
        pick_valid = req_wr | req_rd;
        winner     = WR;
        if (req_wr && req_rd) begin
            winner = (last_owner == WR) ? RD : WR;
        end else if (req_rd) begin
            winner = RD;
        end
    end

endmodule

// File: rtl/axi_sram_port_arbiter.sv
// Shares the byte-wide SRAM port between the write chunk breaker and the read
// byte assembler, granting whole bursts in round-robin order.
module axi_sram_port_arbiter
    import axi_sram_pkg::*;
#(
    parameter int SRAM_ADDR_WIDTH = SRAM_ADDR_W,
    parameter int SRAM_DATA_WIDTH = SRAM_DATA_W,
    parameter int MAX_BEATS       = MAX_BEATS_DEF,
    parameter int BEAT_CNT_WIDTH  = BEAT_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_req,
    input  logic                       wr_last,
    input  logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
    input  logic [SRAM_DATA_WIDTH-1:0] wr_data,
    output logic                       wr_gnt,
    input  logic                       rd_req,
    input  logic                       rd_last,
    input  logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
    output logic                       rd_gnt,
    output logic [SRAM_DATA_WIDTH-1:0] rd_data,
    output logic                       rd_data_valid,
    output logic                       sram_ce,
    output logic                       sram_we,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wdata,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rdata,
    output logic                       burst_trunc
);

    localparam logic [BEAT_CNT_WIDTH-1:0] LAST_CNT = BEAT_CNT_WIDTH'(MAX_BEATS - 1);
    localparam logic [BEAT_CNT_WIDTH-1:0] CNT_ONE  = BEAT_CNT_WIDTH'(1);

    arb_state_t                state_q, state_d;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    owner_t                    last_owner_q, last_owner_d;
    logic                      rd_data_valid_q, rd_data_valid_d;
    logic                      burst_trunc_q, burst_trunc_d;
    logic                      end_beat;
    logic                      pick_valid;
    owner_t                    pick_winner;

    axi_sram_rr_pick u_rr_pick (
        .req_wr     (wr_req),
        .req_rd     (rd_req),
        .last_owner (last_owner_q),
        .pick_valid (pick_valid),
        .winner     (pick_winner)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            beat_cnt_q      <= '0;
            last_owner_q    <= RD;
            rd_data_valid_q <= 1'b0;
            burst_trunc_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_cnt_q      <= beat_cnt_d;
            last_owner_q    <= last_owner_d;
            rd_data_valid_q <= rd_data_valid_d;
            burst_trunc_q   <= burst_trunc_d;
        end
    end

    // A burst ends on its last beat or when the beat budget is used up; a
    // bubble (owner req low) holds the grant without touching the SRAM.
    always_comb begin
        state_d         = state_q;
        beat_cnt_d      = beat_cnt_q;
        last_owner_d    = last_owner_q;
        rd_data_valid_d = 1'b0;
        burst_trunc_d   = 1'b0;
        end_beat        = 1'b0;
        sram_ce         = 1'b0;
        sram_we         = 1'b0;
        sram_addr       = '0;
        sram_wdata      = '0;

        case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                if (pick_valid) begin
                    state_d = (pick_winner == WR) ? WR_BURST : RD_BURST;
                end
            end
            WR_BURST: begin
                if (wr_req) begin
                    sram_ce    = 1'b1;
                    sram_we    = 1'b1;
                    sram_addr  = wr_addr;
                    sram_wdata = wr_data;
                    end_beat   = wr_last || (beat_cnt_q == LAST_CNT);
                    if (end_beat) begin
                        state_d       = IDLE;
                        beat_cnt_d    = '0;
                        last_owner_d  = WR;
                        burst_trunc_d = !wr_last;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_ONE;
                    end
                end
            end
            RD_BURST: begin
                if (rd_req) begin
                    sram_ce         = 1'b1;
                    sram_addr       = rd_addr;
                    rd_data_valid_d = 1'b1;
                    end_beat        = rd_last || (beat_cnt_q == LAST_CNT);
                    if (end_beat) begin
                        state_d       = IDLE;
                        beat_cnt_d    = '0;
                        last_owner_d  = RD;
                        burst_trunc_d = !rd_last;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    assign wr_gnt        = (state_q == WR_BURST);
    assign rd_gnt        = (state_q == RD_BURST);
    assign rd_data       = sram_rdata;
    assign rd_data_valid = rd_data_valid_q;
    assign burst_trunc   = burst_trunc_q;

endmodule

// File: tb/tb_axi_sram_port_arbiter.sv
// Self-checking bench for axi_sram_port_arbiter: a behavioural SRAM plus an
// expected-memory image drive randomized bursts and directed corner cases.
module tb_axi_sram_port_arbiter;

    logic       clk;
    logic       reset;
    logic       wr_req, wr_last, rd_req, rd_last;
    logic [9:0] wr_addr, rd_addr, sram_addr;
    logic [7:0] wr_data, rd_data, sram_wdata, sram_rdata;
    logic       wr_gnt, rd_gnt, rd_data_valid, sram_ce, sram_we, burst_trunc;

    logic [7:0] mem     [0:1023];
    logic [7:0] exp_mem [0:1023];

    int tests_run;
    int tests_failed;

    axi_sram_port_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .wr_req        (wr_req),
        .wr_last       (wr_last),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_gnt        (wr_gnt),
        .rd_req        (rd_req),
        .rd_last       (rd_last),
        .rd_addr       (rd_addr),
        .rd_gnt        (rd_gnt),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .sram_ce       (sram_ce),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata),
        .burst_trunc   (burst_trunc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural SRAM with one-cycle read latency
    always @(posedge clk) begin
        if (sram_ce && sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_ce && !sram_we) sram_rdata <= mem[sram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit is_wr, input bit req, input bit last,
                         input logic [9:0] a, input logic [7:0] d);
        if (is_wr) begin
            wr_req = req; wr_last = last; wr_addr = a; wr_data = d;
            rd_req = 1'b0; rd_last = 1'b0; rd_addr = '0;
        end else begin
            rd_req = req; rd_last = last; rd_addr = a;
            wr_req = 1'b0; wr_last = 1'b0; wr_addr = '0; wr_data = '0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wr_req = 1'b1; wr_last = 1'b0; wr_addr = 10'h3FF; wr_data = 8'hFF;
        rd_req = 1'b1; rd_last = 1'b1; rd_addr = 10'h155;
        step();
        step();
        #2;
        tests_run++;
        if ({wr_gnt, rd_gnt, sram_ce, sram_we, rd_data_valid, burst_trunc} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 000000",
                     {wr_gnt, rd_gnt, sram_ce, sram_we, rd_data_valid, burst_trunc});
        end
        tests_run++;
        if ({sram_addr, sram_wdata} !== 18'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bus: got %h, expected 0", {sram_addr, sram_wdata});
        end
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        step();
    endtask

    // One requester, n beats, optional bubble of bub_len cycles after beat bub_at
    task automatic test_burst(input bit is_wr, input logic [9:0] base, input int n,
                              input int bub_at, input int bub_len, input int data0);
        logic [9:0]  a;
        logic [7:0]  d;
        logic [7:0]  pend_data;
        bit          pend;
        logic [21:0] exp_v;
        pend = 1'b0;
        pend_data = '0;
        d = (data0 >= 0) ? 8'(data0) : 8'($urandom);
        drive(is_wr, 1'b1, (n == 1), base, d);
        #2;
        tests_run++;
        if ({wr_gnt, rd_gnt, sram_ce} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL arb_cycle: got %b, expected 000", {wr_gnt, rd_gnt, sram_ce});
        end
        step();
        for (int i = 0; i < n; i++) begin
            a = base + 10'(i);
            d = (data0 >= 0) ? 8'(data0 + i) : 8'($urandom);
            drive(is_wr, 1'b1, (i == n - 1), a, d);
            #2;
            exp_v = {is_wr, !is_wr, 1'b1, is_wr, a, (is_wr ? d : 8'h00)};
            tests_run++;
            if ({wr_gnt, rd_gnt, sram_ce, sram_we, sram_addr, sram_wdata} !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL beat%0d: got %h, expected %h", i,
                         {wr_gnt, rd_gnt, sram_ce, sram_we, sram_addr, sram_wdata}, exp_v);
            end
            tests_run++;
            if (pend) begin
                if ({rd_data_valid, rd_data} !== {1'b1, pend_data}) begin
                    tests_failed++;
                    $display("[TB] FAIL rd_return: got %h, expected %h",
                             {rd_data_valid, rd_data}, {1'b1, pend_data});
                end
            end else if (rd_data_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL rd_valid_idle: got %b, expected 0", rd_data_valid);
            end
            if (is_wr) begin
                exp_mem[a] = d;
            end else begin
                pend = 1'b1;
                pend_data = exp_mem[a];
            end
            step();
            if (i == bub_at - 1) begin
                for (int b = 0; b < bub_len; b++) begin
                    drive(is_wr, 1'b0, 1'b1, 10'($urandom), 8'($urandom));
                    #2;
                    tests_run++;
                    if ({wr_gnt, rd_gnt, sram_ce} !== {is_wr, !is_wr, 1'b0}) begin
                        tests_failed++;
                        $display("[TB] FAIL bubble: got %b, expected %b",
                                 {wr_gnt, rd_gnt, sram_ce}, {is_wr, !is_wr, 1'b0});
                    end
                    tests_run++;
                    if (rd_data_valid !== pend || (pend && rd_data !== pend_data)) begin
                        tests_failed++;
                        $display("[TB] FAIL bubble_rd: got %h, expected %h",
                                 {rd_data_valid, rd_data}, {pend, pend_data});
                    end
                    pend = 1'b0;
                    step();
                end
            end
        end
        drive(is_wr, 1'b0, 1'b0, '0, '0);
        #2;
        tests_run++;
        if ({wr_gnt, rd_gnt, sram_ce, burst_trunc} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL burst_end: got %b, expected 0000",
                     {wr_gnt, rd_gnt, sram_ce, burst_trunc});
        end
        tests_run++;
        if (rd_data_valid !== pend || (pend && rd_data !== pend_data)) begin
            tests_failed++;
            $display("[TB] FAIL end_rd: got %h, expected %h",
                     {rd_data_valid, rd_data}, {pend, pend_data});
        end
        step();
    endtask

    // Ties right after reset: write first, then read, then write again
    task automatic test_tie();
        logic [9:0]  wa, ra;
        logic [7:0]  d0, d1, d2, p0, p1, p2;
        logic [21:0] exp_v;
        wa = 10'h100; ra = 10'h180;
        d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
        wr_req = 1; wr_last = 0; wr_addr = wa; wr_data = d0;
        rd_req = 1; rd_last = 0; rd_addr = ra;
        #2;
        tests_run++;
        if ({wr_gnt, rd_gnt, sram_ce} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL tie_arb: got %b, expected 000", {wr_gnt, rd_gnt, sram_ce});
        end
        step();
        for (int i = 0; i < 2; i++) begin
            wr_addr = wa + 10'(i); wr_data = (i == 0) ? d0 : d1; wr_last = (i == 1);
            #2;
            exp_v = {1'b1, 1'b0, 1'b1, 1'b1, wr_addr, wr_data};
            tests_run++;
            if ({wr_gnt, rd_gnt, sram_ce, sram_we, sram_addr, sram_wdata} !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL tie_wr%0d: got %h, expected %h", i,
                         {wr_gnt, rd_gnt, sram_ce, sram_we, sram_addr, sram_wdata}, exp_v);
            end
            exp_mem[wr_addr] = wr_data;
            step();
        end
        wr_req = 0; wr_last = 0;
        #2;
        tests_run++;
        if ({wr_gnt, rd_gnt, sram_ce} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL tie_gap: got %b, expected 000", {wr_gnt, rd_gnt, sram_ce});
        end
        step();
        p0 = exp_mem[ra];
        p1 = exp_mem[ra + 10'd1];
        p2 = exp_mem[ra + 10'd2];
        for (int i = 0; i < 2; i++) begin
            rd_addr = ra + 10'(i); rd_last = (i == 1);
            #2;
            exp_v = {1'b0, 1'b1, 1'b1, 1'b0, rd_addr, 8'h00};
            tests_run++;
            if ({wr_gnt, rd_gnt, sram_ce, sram_we, sram_addr, sram_wdata} !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL tie_rd%0d: got %h, expected %h", i,
                         {wr_gnt, rd_gnt, sram_ce, sram_we, sram_addr, sram_wdata}, exp_v);
            end
            step();
        end
        wr_req = 1; wr_last = 1; wr_addr = wa + 10'd2; wr_data = d2;
        rd_req = 1; rd_last = 1; rd_addr = ra + 10'd2;
        #2;
        tests_run++;
        if ({wr_gnt, rd_gnt, sram_ce, rd_data_valid, rd_data} !== {4'b0001, p1}) begin
            tests_failed++;
            $display("[TB] FAIL tie2_arb: got %h, expected %h",
                     {wr_gnt, rd_gnt, sram_ce, rd_data_valid, rd_data}, {4'b0001, p1});
        end
        step();
        #2;
        exp_v = {1'b1, 1'b0, 1'b1, 1'b1, wa + 10'd2, d2};
        tests_run++;
        if ({wr_gnt, rd_gnt, sram_ce, sram_we, sram_addr, sram_wdata} !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL tie2_wr: got %h, expected %h",
                     {wr_gnt, rd_gnt, sram_ce, sram_we, sram_addr, sram_wdata}, exp_v);
        end
        exp_mem[wa + 10'd2] = d2;
        step();
        wr_req = 0; wr_last = 0;
        #2;
        tests_run++;
        if ({wr_gnt, rd_gnt, sram_ce} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL tie2_gap: got %b, expected 000", {wr_gnt, rd_gnt, sram_ce});
        end
        step();
        #2;
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, ra + 10'd2, 8'h00};
        tests_run++;
        if ({wr_gnt, rd_gnt, sram_ce, sram_we, sram_addr, sram_wdata} !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL tie2_rd: got %h, expected %h",
                     {wr_gnt, rd_gnt, sram_ce, sram_we, sram_addr, sram_wdata}, exp_v);
        end
        step();
        rd_req = 0; rd_last = 0;
        #2;
        tests_run++;
        if ({wr_gnt, rd_gnt, rd_data_valid, rd_data} !== {3'b001, p2}) begin
            tests_failed++;
            $display("[TB] FAIL tie2_ret: got %h, expected %h",
                     {wr_gnt, rd_gnt, rd_data_valid, rd_data}, {3'b001, p2});
        end
        step();
    endtask

    // Nine beats without wr_last: eight go out, the ninth is a new burst
    task automatic test_truncation();
        logic [9:0]  base;
        logic [7:0]  d;
        logic [21:0] exp_v;
        base = 10'h200;
        drive(1'b1, 1'b1, 1'b0, base, 8'($urandom));
        step();
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            drive(1'b1, 1'b1, 1'b0, base + 10'(i), d);
            #2;
            tests_run++;
            if ({wr_gnt, sram_ce, burst_trunc, sram_addr, sram_wdata} !== {3'b110, base + 10'(i), d}) begin
                tests_failed++;
                $display("[TB] FAIL trunc_beat%0d: got %h, expected %h", i,
                         {wr_gnt, sram_ce, burst_trunc, sram_addr, sram_wdata},
                         {3'b110, base + 10'(i), d});
            end
            exp_mem[base + 10'(i)] = d;
            step();
        end
        d = 8'($urandom);
        drive(1'b1, 1'b1, 1'b1, base + 10'd8, d);
        #2;
        tests_run++;
        if ({wr_gnt, sram_ce, burst_trunc} !== 3'b001) begin
            tests_failed++;
            $display("[TB] FAIL trunc_pulse: got %b, expected 001", {wr_gnt, sram_ce, burst_trunc});
        end
        step();
        #2;
        exp_v = {1'b1, 1'b1, 1'b0, 1'b1, base + 10'd8, d};
        tests_run++;
        if ({wr_gnt, sram_ce, burst_trunc, sram_we, sram_addr, sram_wdata} !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL trunc_ninth: got %h, expected %h",
                     {wr_gnt, sram_ce, burst_trunc, sram_we, sram_addr, sram_wdata}, exp_v);
        end
        exp_mem[base + 10'd8] = d;
        step();
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        #2;
        tests_run++;
        if ({wr_gnt, sram_ce, burst_trunc} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL trunc_after: got %b, expected 000", {wr_gnt, sram_ce, burst_trunc});
        end
        step();
    endtask

    task automatic test_reset_mid_burst();
        logic [9:0] ra;
        ra = 10'h300;
        drive(1'b0, 1'b1, 1'b0, ra, '0);
        step();
        drive(1'b0, 1'b1, 1'b0, ra, '0);
        step();
        drive(1'b0, 1'b1, 1'b0, ra + 10'd1, '0);
        reset = 1'b0;
        step();
        #2;
        tests_run++;
        if ({wr_gnt, rd_gnt, sram_ce, sram_we, rd_data_valid, burst_trunc, sram_addr, sram_wdata} !== 24'h0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: got %h, expected 0",
                     {wr_gnt, rd_gnt, sram_ce, sram_we, rd_data_valid, burst_trunc, sram_addr, sram_wdata});
        end
        step();
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, ra + 10'd5, '0);
        #2;
        tests_run++;
        if ({rd_gnt, sram_ce, rd_data_valid} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_arb: got %b, expected 000", {rd_gnt, sram_ce, rd_data_valid});
        end
        step();
        #2;
        tests_run++;
        if ({rd_gnt, sram_ce, sram_we, sram_addr} !== {3'b110, ra + 10'd5}) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_rd: got %h, expected %h",
                     {rd_gnt, sram_ce, sram_we, sram_addr}, {3'b110, ra + 10'd5});
        end
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        #2;
        tests_run++;
        if ({rd_gnt, rd_data_valid, rd_data} !== {2'b01, exp_mem[ra + 10'd5]}) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_ret: got %h, expected %h",
                     {rd_gnt, rd_data_valid, rd_data}, {2'b01, exp_mem[ra + 10'd5]});
        end
        step();
    endtask

    task automatic test_random_bursts();
        int n;
        for (int k = 0; k < 10; k++) begin
            n = int'($urandom_range(1, 8));
            test_burst(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1015)), n,
                       int'($urandom_range(0, n - 1)), int'($urandom_range(1, 3)), -1);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 1024; i++) begin
            mem[i] <= 8'(i * 37 + 11);
            exp_mem[i] = 8'(i * 37 + 11);
        end
        test_reset();
        test_tie();
        test_burst(1'b1, 10'h010, 4, 0, 0, 8'hA0);
        mem[10'h020] <= 8'h5A;
        mem[10'h021] <= 8'hC3;
        exp_mem[10'h020] = 8'h5A;
        exp_mem[10'h021] = 8'hC3;
        step();
        test_burst(1'b0, 10'h020, 2, 0, 0, 0);
        test_burst(1'b1, 10'h040, 8, 3, 3, -1);
        test_burst(1'b0, 10'h040, 8, 2, 3, 0);
        test_truncation();
        test_random_bursts();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axi_sram_port_arbiter.md
Name: axi_sram_port_arbiter

Overview:
- Shares the single byte-wide SRAM port between two burst requesters:
  - the write-side chunk breaker, which turns AXI write data into byte beats;
  - the read-side byte assembler, which turns byte beats back into AXI read data.
- Grants the port for a whole burst, using round-robin between the two requesters.
- Drives SRAM control, address and write data.
- Returns read data with a valid strobe aligned to the 1-cycle SRAM read latency.

Parameters:
- SRAM_ADDR_WIDTH, 10, SRAM byte-address width.
- SRAM_DATA_WIDTH, 8, SRAM word (beat) width.
- MAX_BEATS, 8, maximum beats per granted burst (one 64-bit AXI beat).
- BEAT_CNT_WIDTH, 4, beat counter width; must satisfy 2**BEAT_CNT_WIDTH > MAX_BEATS.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset; block is in reset when reset==0.
- wr_req  input  1  write requester has a beat valid.
- wr_last  input  1  current write beat is the last of its burst.
- wr_addr  input  SRAM_ADDR_WIDTH  write beat address.
- wr_data  input  SRAM_DATA_WIDTH  write beat data.
- wr_gnt  output  1  write requester owns the port.
- rd_req  input  1  read requester has a beat valid.
- rd_last  input  1  current read beat is the last of its burst.
- rd_addr  input  SRAM_ADDR_WIDTH  read beat address.
- rd_gnt  output  1  read requester owns the port.
- rd_data  output  SRAM_DATA_WIDTH  read data returned to the read requester.
- rd_data_valid  output  1  rd_data is valid this cycle.
- sram_ce  output  1  SRAM chip enable.
- sram_we  output  1  SRAM write enable (1 = write).
- sram_addr  output  SRAM_ADDR_WIDTH  SRAM address.
- sram_wdata  output  SRAM_DATA_WIDTH  SRAM write data.
- sram_rdata  input  SRAM_DATA_WIDTH  SRAM read data, valid 1 cycle after a read access.
- burst_trunc  output  1  1-cycle pulse: a burst was cut off at MAX_BEATS without its last beat.

Behaviour:
- Reset values (reset==0 at a clock edge), effective the next cycle:
  - state=IDLE, beat_cnt=0, last_owner=RD (so a write wins the first tie);
  - wr_gnt, rd_gnt, sram_ce, sram_we, rd_data_valid and burst_trunc all 0;
  - sram_addr=0, sram_wdata=0.
- Reset mid-burst aborts the burst. No further SRAM access occurs, and any pending rd_data_valid is dropped.
- FSM states: IDLE, WR_BURST, RD_BURST.
- IDLE:
  - wr_req only -> WR_BURST.
  - rd_req only -> RD_BURST.
  - Both requesting -> the owner that was not last_owner wins.
  - Neither requesting -> stay in IDLE.
  - No SRAM access in IDLE. Arbitration costs exactly 1 cycle.
- Grants are Moore outputs: wr_gnt=1 exactly in WR_BURST; rd_gnt=1 exactly in RD_BURST.
- A beat transfers in a cycle where req && gnt for the owner.
- SRAM drive during a beat is combinational from the owner's inputs:
  - sram_ce=1;
  - sram_we=1 for a write beat, 0 for a read beat;
  - sram_addr = owner's address;
  - sram_wdata = wr_data on writes, 0 otherwise.
- No beat transfers (and the SRAM is held at ce=0, we=0, addr=0, wdata=0):
  - in any cycle without a transfer;
  - in either burst state when the owner's req is 0. The grant is held and the cycle is a bubble; no timeout.
- beat_cnt:
  - increments on each transferred beat;
  - clears on leaving a burst state.
- Burst end: on a transferred beat with last==1 or beat_cnt==MAX_BEATS-1:
  - next state is IDLE;
  - last_owner is set to the burst's owner;
  - the grant drops the following cycle.
- burst_trunc pulses for one cycle (the cycle after the end beat) when the end was caused by beat_cnt==MAX_BEATS-1 with last==0.
- Read return:
  - rd_data_valid is a registered copy of "read beat transferred", so it is 1 exactly one cycle after each read beat;
  - rd_data = sram_rdata, passed through combinationally;
  - a read burst followed immediately by a write grant is legal. The final read data returns in the arbitration IDLE cycle, with no conflict.
- Inputs from the non-owner are ignored entirely.
- wr_last and rd_last are only sampled on transferred beats.
- The minimum gap between consecutive bursts is 1 IDLE cycle.

Decomposition:
- Package axi_sram_pkg holds:
  - the owner_t enum (WR, RD);
  - the arb_state_t enum (IDLE, WR_BURST, RD_BURST);
  - SRAM width constants shared with the chunk breaker.
- One sub-module is natural: axi_sram_rr_pick. It is a combinational 2-way round-robin pick (inputs: two requests plus last_owner; output: the winner), reusable when a third requester is added later.
- The FSM, beat counter and SRAM mux live in the top module.

Test Plan:
- Single write: wr_req with 4 beats at addr 0x010..0x013, data 0xA0..0xA3, wr_last on beat 4.
  -> wr_gnt rises 1 cycle after wr_req.
  -> 4 cycles with sram_ce=1, sram_we=1, correct addr/data.
  -> wr_gnt=0 on the next cycle.
- Single read: 2 beats at 0x020/0x021, with the SRAM model returning 0x5A and 0xC3.
  -> rd_data_valid is high on the 2 cycles after each beat, with rd_data 0x5A then 0xC3.
  -> sram_we=0 throughout.
- Simultaneous wr_req and rd_req out of reset.
  -> Write is granted first.
  -> After wr_last, 1 IDLE cycle, then rd_gnt.
  -> A second tie after that grants the write again, because last_owner=RD.
- Bubble: the owner drops req for 3 cycles mid-burst.
  -> Grant is held, sram_ce=0 for those 3 cycles, beat_cnt unchanged.
  -> The burst completes normally.
- Truncation: a write burst of 9 beats with wr_last never asserted.
  -> The burst ends after beat 8.
  -> burst_trunc pulses once.
  -> The 9th beat is re-arbitrated as a new burst.
- Reset mid-burst: drive reset=0 after beat 2 of a read.
  -> Next cycle all outputs are 0 and no rd_data_valid pulse appears for beat 2.
  -> After reset=1, a fresh rd_req is granted after 1 cycle.
